bu_diag_seq: RTL and testbench

//  Sequencer for the pipelined squared-difference unit (fpsub -> fpsquare, result (a-b)^2).

---
 rtl/bu_diag_seq.sv | 199 +++++++++++++++++++
 tb/tb_bu_diag_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bu_diag_seq.sv
// bu_diag_seq: sequencer for the pipelined squared-difference unit, result (a-b)^2.
// Streams len element pairs from two source RAMs into the datapath, one per cycle. Each
// returned result is written to the result buffer in issue order. Overflow and underflow
// status are collected as sticky flags. A watchdog catches results that never arrive.
//
// Ports:
//   clock, aclr_n                    clock and asynchronous active-low reset
//   start, len                       run request; len is sampled when start is accepted
//   ready, busy, done                handshake and status
//   rd_en, rd_addr                   source RAM read; rd_data_a/b are valid one cycle later
//   dp_clk_en, dp_a, dp_b, dp_in_flag     datapath operand side
//   dp_result, dp_avail, dp_ovf, dp_unf   datapath result side
//   wr_en, wr_addr, wr_data          result buffer write
//   err_ovf, err_unf, err_tmo        sticky error flags
`timescale 1ns/1ps
module bu_diag_seq #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned LAT    = 23,
  parameter int unsigned WD_SLK = 4
) (
  input  logic              clock,
  input  logic              aclr_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data_a,
  input  logic [31:0]       rd_data_b,
  output logic              dp_clk_en,
  output logic [31:0]       dp_a,
  output logic [31:0]       dp_b,
  output logic              dp_in_flag,
  input  logic [31:0]       dp_result,
  input  logic              dp_avail,
  input  logic              dp_ovf,
  input  logic              dp_unf,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err_ovf,
  output logic              err_unf,
  output logic              err_tmo
);

  localparam int unsigned LenW = ADDR_W + 1;
  localparam int unsigned FlW  = $clog2(LAT + 2) + 1;
  localparam int unsigned WdW  = $clog2(LAT + WD_SLK + 1) + 1;

  localparam logic [FlW-1:0] FlushLast = FlW'(LAT + 1);
  localparam logic [WdW-1:0] WdLimit   = WdW'(LAT + WD_SLK);

  typedef enum logic [2:0] {StFlush, StIdle, StIssue, StDrain, StDone} state_e;

  state_e              state_q;
  logic [FlW-1:0]      flush_cnt_q;
  logic [LenW-1:0]     len_q;
  logic [LenW-1:0]     wr_cnt_q;
  logic [WdW-1:0]      wd_q;
  logic                ready_q, busy_q, done_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                dp_in_flag_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [31:0]         wr_data_q;
  logic                err_ovf_q, err_unf_q, err_tmo_q;

  logic res_ok;
  logic last_rd;

  // A result counts only while a run is collecting and still owes results.
  assign res_ok  = dp_avail && ((state_q == StIssue) || (state_q == StDrain)) &&
                   (wr_cnt_q < len_q);
  assign last_rd = ({1'b0, rd_addr_q} == (len_q - LenW'(1)));

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q      <= StFlush;
      flush_cnt_q  <= '0;
      len_q        <= '0;
      wr_cnt_q     <= '0;
      wd_q         <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      dp_in_flag_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_ovf_q    <= 1'b0;
      err_unf_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      dp_in_flag_q <= rd_en_q;

      wr_en_q <= res_ok;
      if (res_ok) begin
        wr_addr_q <= wr_cnt_q[ADDR_W-1:0];
        wr_data_q <= dp_result;
        wr_cnt_q  <= wr_cnt_q + LenW'(1);
        if (dp_ovf) err_ovf_q <= 1'b1;
        if (dp_unf) err_unf_q <= 1'b1;
      end

      // Any sign of life from either side of the datapath restarts the watchdog.
      if (dp_in_flag_q || res_ok) begin
        wd_q <= '0;
      end else if (wd_q != WdLimit) begin
        wd_q <= wd_q + WdW'(1);
      end

      case (state_q)
        StFlush: begin
          if (flush_cnt_q == FlushLast) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + FlW'(1);
          end
        end
        StIdle: begin
          if (start) begin
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            len_q     <= len;
            wr_cnt_q  <= '0;
            wd_q      <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            err_tmo_q <= 1'b0;
            if (len != '0) begin
              state_q   <= StIssue;
              rd_en_q   <= 1'b1;
              rd_addr_q <= '0;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (last_rd) begin
            rd_en_q <= 1'b0;
            state_q <= StDrain;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        StDrain: begin
          if (wr_cnt_q == len_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if ((wd_q == WdLimit) && !res_ok) begin
            // Give up on the missing results; the following flush swallows stragglers.
            err_tmo_q <= 1'b1;
            state_q   <= StDone;
            done_q    <= 1'b1;
          end
        end
        StDone: begin
          busy_q <= 1'b0;
          if (err_tmo_q) begin
            state_q     <= StFlush;
            flush_cnt_q <= '0;
          end else begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= StFlush;
      endcase
    end
  end

  // RAM data arrives one cycle after rd_en, aligned with the registered operand strobe.
  assign dp_a       = dp_in_flag_q ? rd_data_a : '0;
  assign dp_b       = dp_in_flag_q ? rd_data_b : '0;
  assign dp_in_flag = dp_in_flag_q;
  assign dp_clk_en  = busy_q;

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;
  assign err_tmo = err_tmo_q;

endmodule

// File: tb/tb_bu_diag_seq.sv
// tb_bu_diag_seq: directed bench for bu_diag_seq with a RAM model and an ideal LAT-cycle
// squared-difference datapath model whose valid pipe has no reset.
`timescale 1ns/1ps
module tb_bu_diag_seq;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned LAT    = 23;
  localparam int unsigned WD_SLK = 4;
  localparam logic [31:0] One    = 32'h3F80_0000;

  logic              clock = 1'b0;
  logic              aclr_n, start;
  logic [ADDR_W:0]   len;
  logic              ready, busy, done, rd_en, dp_clk_en, dp_in_flag, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [31:0]       rd_data_a = '0, rd_data_b = '0;
  logic [31:0]       dp_a, dp_b, dp_result, wr_data;
  logic              dp_avail, dp_ovf;
  logic              dp_unf = 1'b0;
  logic              err_ovf, err_unf, err_tmo;

  always #5 clock = ~clock;

  bu_diag_seq #(.ADDR_W(ADDR_W), .LAT(LAT), .WD_SLK(WD_SLK)) dut (
    .clock(clock), .aclr_n(aclr_n), .start(start), .len(len), .ready(ready), .busy(busy),
    .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b), .dp_clk_en(dp_clk_en), .dp_a(dp_a), .dp_b(dp_b),
    .dp_in_flag(dp_in_flag), .dp_result(dp_result), .dp_avail(dp_avail), .dp_ovf(dp_ovf),
    .dp_unf(dp_unf), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_tmo(err_tmo)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Element i: a = i+2, b = 1.0, so (a-b)^2 = (i+1)^2, all as fp32.
  function automatic logic [31:0] a_of(input logic [3:0] i);
    case (i)
      4'd0: return 32'h4000_0000;
      4'd1: return 32'h4040_0000;
      4'd2: return 32'h4080_0000;
      4'd3: return 32'h40A0_0000;
      4'd4: return 32'h40C0_0000;
      4'd5: return 32'h40E0_0000;
      4'd6: return 32'h4100_0000;
      4'd7: return 32'h4110_0000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] sq_of(input logic [3:0] i);
    case (i)
      4'd0: return 32'h3F80_0000;
      4'd1: return 32'h4080_0000;
      4'd2: return 32'h4110_0000;
      4'd3: return 32'h4180_0000;
      4'd4: return 32'h41C8_0000;
      4'd5: return 32'h4210_0000;
      4'd6: return 32'h4244_0000;
      4'd7: return 32'h4280_0000;
      default: return 32'hBAD0_0001;
    endcase
  endfunction

  function automatic logic [31:0] dp_fn(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 8; i++) begin
      if (a == a_of(i[3:0]) && b == One) return sq_of(i[3:0]);
    end
    return 32'hBAD0_0000;
  endfunction

  always @(posedge clock) begin
    if (rd_en) begin
      rd_data_a <= a_of(rd_addr);
      rd_data_b <= One;
    end
  end

  // Datapath model: valid pipe deliberately unreset.
  logic        pipe_v [LAT];
  logic [31:0] pipe_r [LAT];
  int out_cnt = 0;
  int drop_at = -1;
  int ovf_at  = -1;

  always @(posedge clock) begin
    pipe_v[0] <= dp_in_flag;
    pipe_r[0] <= dp_fn(dp_a, dp_b);
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_r[i] <= pipe_r[i-1];
    end
    if (pipe_v[LAT-1]) out_cnt <= out_cnt + 1;
  end

  assign dp_avail  = pipe_v[LAT-1] && (out_cnt != drop_at);
  assign dp_ovf    = dp_avail && (out_cnt == ovf_at);
  assign dp_result = pipe_r[LAT-1];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int first_rd, last_rd, nrd, ord_err, first_flag, nflag, first_wr, last_wr, nwr, wr_err;
  int done_c, nbusy, ovf_first, ovf_c1, tmo_done, ready_c, busy_after;
  int rdy_err, r6_wr, r6_rd, r6_ready;

  // Starts a run in the current cycle (cycle 0) and logs activity per cycle.
  task automatic run(input int l, input int pulse_at, input int budget);
    first_rd = -1; last_rd = -1; nrd = 0; ord_err = 0; first_flag = -1; nflag = 0;
    first_wr = -1; last_wr = -1; nwr = 0; wr_err = 0; done_c = -1; nbusy = 0;
    ovf_first = -1; ovf_c1 = -1; tmo_done = -1; ready_c = -1; busy_after = -1;
    start = 1'b1;
    len   = l[ADDR_W:0];
    for (int c = 1; c <= budget; c++) begin
      step();
      start = (c == pulse_at);
      if (rd_en) begin
        if (first_rd < 0) first_rd = c;
        if (rd_addr != nrd[3:0]) ord_err++;
        last_rd = c;
        nrd++;
      end
      if (dp_in_flag) begin
        if (first_flag < 0) first_flag = c;
        nflag++;
      end
      if (wr_en) begin
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        if (wr_addr != nwr[3:0] || wr_data != sq_of(wr_addr)) wr_err++;
        nwr++;
      end
      if (busy) nbusy++;
      if (c == 1) ovf_c1 = int'(err_ovf);
      if (err_ovf && ovf_first < 0) ovf_first = c;
      if (done) begin
        done_c   = c;
        tmo_done = int'(err_tmo);
      end
      if (done_c >= 0 && c == done_c + 1) busy_after = int'(busy);
      if (done_c >= 0 && c > done_c && ready) begin
        ready_c = c;
        break;
      end
    end
    start = 1'b0;
    chk("run_bound", (done_c >= 0) && (ready_c >= 0), 1);
  endtask

  initial begin
    aclr_n = 1'b0;
    start  = 1'b0;
    len    = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_outs", |{ready, busy, done, rd_en, rd_addr, dp_clk_en, dp_a, dp_b, dp_in_flag,
                      wr_en, wr_addr, wr_data, err_ovf, err_unf, err_tmo}, 0);

    // T1: release in cycle 0; start held through the flush must be ignored.
    aclr_n = 1'b1;
    start  = 1'b1;
    len    = 5'd3;
    rdy_err = 0;
    for (int c = 1; c <= LAT + 1; c++) begin
      step();
      if (ready || busy || rd_en) rdy_err++;
    end
    chk("flush_ignore", rdy_err, 0);
    step();
    start = 1'b0;
    step();
    chk("ready_lat3", ready, 1);

    // T2: len=8, stray start at cycle 5.
    run(8, 5, 120);
    chk("t2_first_rd", first_rd, 1);
    chk("t2_last_rd", last_rd, 8);
    chk("t2_nrd", nrd, 8);
    chk("t2_rd_order", ord_err, 0);
    chk("t2_first_flag", first_flag, 2);
    chk("t2_nflag", nflag, 8);
    chk("t2_first_wr", first_wr, 26);
    chk("t2_last_wr", last_wr, 33);
    chk("t2_nwr", nwr, 8);
    chk("t2_wr_data", wr_err, 0);
    chk("t2_done", done_c, 34);
    chk("t2_nbusy", nbusy, 34);
    chk("t2_busy_after", busy_after, 0);
    chk("t2_ready", ready_c, 35);
    chk("t2_errs", {err_ovf, err_unf, err_tmo}, 0);

    // T3: len=0.
    run(0, 0, 20);
    chk("t3_done", done_c, 1);
    chk("t3_nrd", nrd, 0);
    chk("t3_nflag", nflag, 0);
    chk("t3_nwr", nwr, 0);
    chk("t3_nbusy", nbusy, 1);
    chk("t3_ready", ready_c, 2);

    // T4: overflow on the 3rd result.
    ovf_at = out_cnt + 2;
    run(4, 0, 80);
    ovf_at = -1;
    chk("t4_ovf_first", ovf_first, 28);
    chk("t4_done", done_c, 30);
    chk("t4_nwr", nwr, 4);
    chk("t4_wr_data", wr_err, 0);
    chk("t4_ovf_held", err_ovf, 1);
    chk("t4_unf", err_unf, 0);

    // T5: 4th result lost; watchdog counts from the last delivered result (cycle 27).
    drop_at = out_cnt + 3;
    run(4, 0, 150);
    drop_at = -1;
    chk("t5_ovf_cleared", ovf_c1, 0);
    chk("t5_nwr", nwr, 3);
    chk("t5_last_wr", last_wr, 28);
    chk("t5_wr_data", wr_err, 0);
    chk("t5_tmo_at_done", tmo_done, 1);
    chk("t5_done", done_c, 56);
    chk("t5_ready", ready_c, 82);
    chk("t5_tmo_held", err_tmo, 1);

    // T6: reset in cycles 4..5 of a len=8 run; residue must not be written.
    start = 1'b1;
    len   = 5'd8;
    r6_wr = 0;
    r6_rd = 0;
    r6_ready = -1;
    for (int c = 1; c <= 80; c++) begin
      step();
      start = 1'b0;
      if (c == 4) begin
        aclr_n = 1'b0;
        #1;
        chk("t6_rst_outs", |{ready, busy, done, rd_en, rd_addr, dp_clk_en, dp_a, dp_b,
                             dp_in_flag, wr_en, wr_addr, wr_data, err_ovf, err_unf,
                             err_tmo}, 0);
      end
      if (c == 6) aclr_n = 1'b1;
      if (c >= 4) begin
        if (wr_en) r6_wr++;
        if (rd_en) r6_rd++;
        if (ready) begin
          r6_ready = c;
          break;
        end
      end
    end
    chk("t6_no_wr", r6_wr, 0);
    chk("t6_no_rd", r6_rd, 0);
    chk("t6_ready", r6_ready, 31);

    run(8, 0, 120);
    chk("t6b_nwr", nwr, 8);
    chk("t6b_wr_data", wr_err, 0);
    chk("t6b_first_wr", first_wr, 26);
    chk("t6b_done", done_c, 34);
    chk("t6b_errs", {err_ovf, err_unf, err_tmo}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
